// File: rtl/vx_inter_pkg.sv
// Shared types and constants for the plane-interpolation scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vx_inter_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] INTER_A = 2'd0;
    localparam logic [1:0] INTER_B = 2'd1;
    localparam logic [1:0] INTER_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_X = 2'd1,
        MUL_Y = 2'd2,
        RSP   = 2'd3
    } state_e;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin pick: first request at or after ptr, wrapping; one-hot plus index.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module vx_rr_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int IDXW     = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] req,
    input  logic [IDXW-1:0]     ptr,
    output logic [NUM_REQS-1:0] gnt,
    output logic [IDXW-1:0]     gnt_idx,
    output logic                gnt_vld
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            logic [IDXW-1:0] cand;
            // NUM_REQS is a power of two, so the truncating add wraps for free
            cand = ptr + IDXW'(i);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/vx_inter_sched.sv
// Round-robin scheduler computing a*x + b*y + c on one shared 32x32 multiplier.
// Latency: grant in cycle 0, rsp_valid in cycle 3; one result per 4 cycles.
// Backpressure: RSP holds data/tag/idx while rsp_ready is low; no grants meanwhile.
module vx_inter_sched
    import vx_inter_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int TAG_WIDTH = 16,
    parameter int REQ_IDXW  = $clog2(NUM_REQS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          csr_write_enable,
    input  logic [1:0]                    csr_write_addr,
    input  logic [REQ_IDXW-1:0]           csr_write_sel,
    input  logic [DATA_W-1:0]             csr_write_data,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*DATA_W-1:0]    req_x,
    input  logic [NUM_REQS*DATA_W-1:0]    req_y,
    input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic [REQ_IDXW-1:0]           rsp_idx,
    output logic                          busy
);

    state_e                state_q, state_d;
    logic [REQ_IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]     x_q, x_d, y_q, y_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [REQ_IDXW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]     snap_a_q, snap_a_d, snap_b_q, snap_b_d, snap_c_q, snap_c_d;
    logic [DATA_W-1:0]     coef_a_q [NUM_REQS];
    logic [DATA_W-1:0]     coef_a_d [NUM_REQS];
    logic [DATA_W-1:0]     coef_b_q [NUM_REQS];
    logic [DATA_W-1:0]     coef_b_d [NUM_REQS];
    logic [DATA_W-1:0]     coef_c_q [NUM_REQS];
    logic [DATA_W-1:0]     coef_c_d [NUM_REQS];

    logic [NUM_REQS-1:0]   gnt_oh;
    logic [REQ_IDXW-1:0]   gnt_idx;
    logic                  gnt_vld;
    logic [DATA_W-1:0]     mul_op_a, mul_op_b, prod;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .IDXW     (REQ_IDXW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Single shared multiplier: coefficient/operand pair chosen by step
    assign mul_op_a = (state_q == MUL_Y) ? snap_b_q : snap_a_q;
    assign mul_op_b = (state_q == MUL_Y) ? y_q      : x_q;
    assign prod     = mul_op_a * mul_op_b;

    // Gated by reset so no handshake can be seen while the block is held in reset
    assign req_ready = (state_q == IDLE && reset) ? gnt_oh : '0;
    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = acc_q;
    assign rsp_tag   = tag_q;
    assign rsp_idx   = idx_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        snap_a_d = snap_a_q;
        snap_b_d = snap_b_q;
        snap_c_d = snap_c_q;
        coef_a_d = coef_a_q;
        coef_b_d = coef_b_q;
        coef_c_d = coef_c_q;

        if (csr_write_enable) begin
            case (csr_write_addr)
                INTER_A: coef_a_d[csr_write_sel] = csr_write_data;
                INTER_B: coef_b_d[csr_write_sel] = csr_write_data;
                INTER_C: coef_c_d[csr_write_sel] = csr_write_data;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    x_d      = req_x[gnt_idx*DATA_W +: DATA_W];
                    y_d      = req_y[gnt_idx*DATA_W +: DATA_W];
                    tag_d    = req_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH];
                    idx_d    = gnt_idx;
                    // Snapshot uses pre-edge coefficients, so a same-cycle write is not seen
                    snap_a_d = coef_a_q[gnt_idx];
                    snap_b_d = coef_b_q[gnt_idx];
                    snap_c_d = coef_c_q[gnt_idx];
                    rr_ptr_d = gnt_idx + REQ_IDXW'(1);
                    state_d  = MUL_X;
                end
            end
            MUL_X: begin
                acc_d   = prod;
                state_d = MUL_Y;
            end
            MUL_Y: begin
                acc_d   = acc_q + prod + snap_c_q;
                state_d = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            tag_q    <= '0;
            idx_q    <= '0;
            snap_a_q <= '0;
            snap_b_q <= '0;
            snap_c_q <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                coef_a_q[i] <= '0;
                coef_b_q[i] <= '0;
                coef_c_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
            snap_c_q <= snap_c_d;
            coef_a_q <= coef_a_d;
            coef_b_q <= coef_b_d;
            coef_c_q <= coef_c_d;
        end
    end

endmodule

// File: doc/vx_inter_sched.md
# vx_inter_sched

Round-robin scheduler and sequencer for the shared plane-interpolation datapath (result = a·x + b·y + c). It holds one coefficient set (a, b, c) per requester and arbitrates NUM_REQS requesters onto a single 32×32 multiplier. Each operation is sequenced in two multiply steps, and the result is returned through a valid/ready response port. It sits between the issue-side interpolation request interfaces and the writeback response path, and replaces the per-request combinational evaluation.

## Interface
- NUM_REQS, 4, number of requesters; ≥2, power of two.
- TAG_WIDTH, 16, opaque per-request tag echoed on the response (uuid/wid/rd packing done by the caller).
- REQ_IDXW, $clog2(NUM_REQS), requester index width (derived).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- csr_write_enable  in  1  coefficient write strobe.
- csr_write_addr  in  2  0=A, 1=B, 2=C; 3 ignored.
- csr_write_sel  in  REQ_IDXW  coefficient set to write.
- csr_write_data  in  32  coefficient value.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_x, req_y  in  NUM_REQS×32  packed operands; slice i belongs to requester i.
- req_tag  in  NUM_REQS×TAG_WIDTH  packed tags.
- req_ready  out  NUM_REQS  one-hot grant; at most one bit high.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer ready.
- rsp_data  out  32  a·x + b·y + c, mod 2^32.
- rsp_tag  out  TAG_WIDTH  tag of the granted request.
- rsp_idx  out  REQ_IDXW  index of the granted requester.
- busy  out  1  high in every state except IDLE.

## Operation
- Arithmetic: unsigned, only the low 32 bits of every product and sum are kept, and overflow wraps silently. The signed interpretation is identical.
- Coefficient registers: written on a clock edge when csr_write_enable is high and the address is valid. Writes are legal in any FSM state.
- FSM states: IDLE → MUL_X → MUL_Y → RSP → IDLE.
- IDLE:
  - If any req_valid bit is high, the arbiter grants the first valid requester at or after rr_ptr (wrapping) and drives req_ready[g]=1 in the same cycle. The handshake completes in that cycle.
  - On that edge the block latches x, y, tag, g and the snapshot of A[g], B[g], C[g], then sets rr_ptr to g+1 mod NUM_REQS and moves to MUL_X.
  - With no valid request it stays in IDLE and all req_ready bits are 0.
- MUL_X: acc ← A·x. Moves to MUL_Y.
- MUL_Y: acc ← acc + B·y + C. Moves to RSP.
- RSP: rsp_valid=1, with rsp_data=acc, rsp_tag and rsp_idx held stable. When rsp_valid&&rsp_ready, the FSM moves to IDLE; otherwise it stays in RSP.
- req_ready is 0 in every state except IDLE.
- The coefficient snapshot is taken at grant, so CSR writes during MUL_X/MUL_Y/RSP do not affect the in-flight result.
- A CSR write in the grant cycle to the granted set is not visible to that operation, because the snapshot reads the pre-edge value.
- csr_write_addr=3 is ignored.
- csr_write_sel ≥ NUM_REQS cannot occur for power-of-two NUM_REQS.
- A requester dropping req_valid before it is granted is legal; that requester simply loses the slot.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, acc=0, all coefficient registers 0.
  - rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_idx=0, busy=0.
  - req_ready=0 while reset is asserted.
- Latency: with the grant in cycle 0, rsp_valid goes high in cycle 3.
- Throughput: one result per 4 cycles with rsp_ready tied high. The next grant occurs in the cycle after the response fires.
- Reset asserted mid-operation (any state): all state clears immediately and asynchronously, the in-flight operation is discarded, and no response is produced after release.
- Backpressure: rsp_valid stays high and rsp_data/tag/idx stay stable for as long as rsp_ready=0. No new grants are made while held.

## Structure
- Package vx_inter_pkg holds:
  - the state enum (IDLE, MUL_X, MUL_Y, RSP);
  - the CSR address constants INTER_A=0, INTER_B=1, INTER_C=2;
  - the 32-bit data width constant.
- Sub-module vx_rr_arbiter (NUM_REQS) takes a request vector and rr_ptr and returns a one-hot grant and its index, combinationally.
- The pointer register stays in vx_inter_sched.
- The multiplier is a single shared `*` instance whose operand mux is selected by state.

## Test plan
- Single op: set 0 programmed A=3, B=5, C=7; req0 x=2, y=4, tag=0x00AB → rsp_data=33, rsp_idx=0, rsp_tag=0x00AB, with rsp_valid high exactly 3 cycles after grant.
- Wrap: A=0xFFFFFFFF, B=0, C=3, x=2, y=9 → rsp_data=0x00000001.
- Fairness: all 4 requesters valid continuously with rsp_ready=1 → grant order 0,1,2,3,0,1, one grant every 4 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RSP → rsp_valid, data, tag and idx constant, req_ready=0 throughout; rsp_ready=1 → fire, then the next grant in the following cycle.
- CSR hazard: set 1 has A=2; in MUL_X write A[1]=10; x=1, y=0, C=0 → first result 2, and a repeat request returns 10.
- Reset mid-op: assert reset during MUL_Y → rsp_valid=0 immediately; after release with no requests, no response, busy=0, and coefficients read back as 0 (a subsequent op returns 0).
